sa_cache_ctrl: RTL and testbench

//  Clocked, parametrised set-associative L1 tag/state controller; one instance per cache (data: WAYS=8, instr: WAYS=4).
//  Per request: tag lookup, true-LRU replacement, per-line MESI update and eviction write-back flag; optional statistics.

---
 rtl/mypkg.sv | 40 ++++
 rtl/sa_cache_lru_upd.sv | 27 ++
 rtl/sa_cache_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_sa_cache_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mypkg.sv
// rtl/mypkg.sv - shared command codes, MESI encoding and address field widths for the L1 controllers
package mypkg;

    typedef enum logic [3:0] {
        CMD_READ       = 4'd0,
        CMD_WRITE      = 4'd1,
        CMD_I_FETCH    = 4'd2,
        CMD_L2_INVAL   = 4'd3,
        CMD_L2_DATA_RQ = 4'd4,
        CMD_CLR        = 4'd8,
        CMD_PRINT      = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        ST_SWEEP,
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE
    } ctrl_state_t;

    function automatic int off_w(input int line_b);
        return $clog2(line_b);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_b);
        return addr_w - $clog2(sets) - $clog2(line_b);
    endfunction

endpackage

// File: rtl/sa_cache_lru_upd.sv
// rtl/sa_cache_lru_upd.sv - combinational true-LRU age update for one set (touched way becomes MRU)
module sa_cache_lru_upd #(
    parameter int WAYS = 8,
    parameter int AW   = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] i_ages,
    input  logic [AW-1:0]           i_way,
    output logic [WAYS-1:0][AW-1:0] o_ages
);

    logic [AW-1:0] w_touched_age;

    assign w_touched_age = i_ages[i_way];

    // Ways younger than the touched one slide down by one; the touched way becomes WAYS-1.
    always_comb begin
        o_ages = i_ages;
        for (int w = 0; w < WAYS; w++) begin
            if (w == int'(i_way)) begin
                o_ages[w] = AW'(WAYS - 1);
            end else if (i_ages[w] > w_touched_age) begin
                o_ages[w] = i_ages[w] - AW'(1);
            end
        end
    end

endmodule

// File: rtl/sa_cache_ctrl.sv
// rtl/sa_cache_ctrl.sv - set-associative L1 tag/MESI/LRU controller; CACHE_STATS_EN adds stat_* counters
module sa_cache_ctrl
    import mypkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16384,
    parameter int WAYS   = 8,
    parameter int LINE_B = 64,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              req_cmd,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic [1:0]              resp_mesi,
    output logic                    resp_wb,
    output logic [ADDR_W-1:0]       resp_wb_addr,
    output logic                    resp_err
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]        stat_rd,
    output logic [CNT_W-1:0]        stat_wr,
    output logic [CNT_W-1:0]        stat_hit,
    output logic [CNT_W-1:0]        stat_miss
`endif
);

    localparam int OFF_W  = off_w(LINE_B);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_B);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = ADDR_W - OFF_W;

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [IDX_W-1:0]  r_sweep_idx;
    logic              r_clr_resp;
    logic [3:0]        r_cmd;
    logic [LINE_W-1:0] r_line;
    logic              r_hit;
    logic [WAY_W-1:0]  r_way;

    logic [TAG_W-1:0]  r_tag_arr  [SETS][WAYS];
    mesi_t             r_mesi_arr [SETS][WAYS];
    logic [WAY_W-1:0]  r_age_arr  [SETS][WAYS];

    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [WAY_W-1:0]  r_resp_way;
    mesi_t             r_resp_mesi;
    logic              r_resp_wb;
    logic [ADDR_W-1:0] r_resp_wb_addr;
    logic              r_resp_err;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_sweep_last;
    logic              w_req_ready;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_inv_found;
    logic [WAY_W-1:0]  w_inv_way;
    logic [WAY_W-1:0]  w_lru_way;
    mesi_t             w_cur_mesi;
    logic [TAG_W-1:0]  w_cur_tag;
    logic [WAYS-1:0][WAY_W-1:0] w_ages_cur;
    logic [WAYS-1:0][WAY_W-1:0] w_ages_new;
    logic              w_do_touch;
    logic              w_do_alloc;
    logic              w_do_mesi;
    mesi_t             w_new_mesi;
    mesi_t             w_resp_mesi;
    logic              w_wb;
    logic [ADDR_W-1:0] w_wb_addr;
    logic              w_err;
    logic              w_is_rd;
    logic              w_is_wr;
    logic              w_unused;

    assign w_idx        = r_line[IDX_W-1:0];
    assign w_tag        = r_line[LINE_W-1:IDX_W];
    assign w_sweep_last = (r_sweep_idx == IDX_W'(SETS - 1));
    assign w_cur_mesi   = r_mesi_arr[w_idx][r_way];
    assign w_cur_tag    = r_tag_arr[w_idx][r_way];
    assign w_unused     = ^req_addr[OFF_W-1:0] ^ (CNT_W > 0);

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            ST_SWEEP:  if (w_sweep_last) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid) w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = (r_cmd == CMD_CLR) ? ST_SWEEP : ST_IDLE;
            default:   w_state_nxt = ST_SWEEP;
        endcase
    end

    assign req_ready = w_req_ready;

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_ages_cur[w] = r_age_arr[w_idx][w];
            if (r_mesi_arr[w_idx][w] != MESI_I && r_tag_arr[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (r_mesi_arr[w_idx][w] == MESI_I && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
            if (r_age_arr[w_idx][w] == '0) w_lru_way = WAY_W'(w);
        end
    end

    sa_cache_lru_upd #(
        .WAYS (WAYS),
        .AW   (WAY_W)
    ) u_lru (
        .i_ages (w_ages_cur),
        .i_way  (r_way),
        .o_ages (w_ages_new)
    );

    // Command decode for the UPDATE cycle; r_way is the hit way or the chosen victim.
    always_comb begin
        w_do_touch  = 1'b0;
        w_do_alloc  = 1'b0;
        w_do_mesi   = 1'b0;
        w_new_mesi  = MESI_I;
        w_resp_mesi = MESI_I;
        w_wb        = 1'b0;
        w_wb_addr   = '0;
        w_err       = 1'b0;
        w_is_rd     = 1'b0;
        w_is_wr     = 1'b0;
        case (r_cmd)
            CMD_READ, CMD_I_FETCH, CMD_WRITE: begin
                w_do_touch = 1'b1;
                w_do_mesi  = 1'b1;
                w_is_wr    = (r_cmd == CMD_WRITE);
                w_is_rd    = !w_is_wr;
                if (r_hit) begin
                    w_new_mesi = w_is_wr ? MESI_M : w_cur_mesi;
                end else begin
                    w_do_alloc = 1'b1;
                    w_new_mesi = w_is_wr ? MESI_M : MESI_E;
                    w_wb       = (w_cur_mesi == MESI_M);
                end
                w_resp_mesi = w_new_mesi;
            end
            CMD_L2_INVAL: begin
                if (r_hit) begin
                    w_do_mesi = 1'b1;
                    w_wb      = (w_cur_mesi == MESI_M);
                end
            end
            CMD_L2_DATA_RQ: begin
                if (r_hit) begin
                    w_do_mesi   = 1'b1;
                    w_new_mesi  = MESI_S;
                    w_resp_mesi = MESI_S;
                    w_wb        = (w_cur_mesi == MESI_M);
                end
            end
            CMD_CLR: ;
            CMD_PRINT: w_resp_mesi = r_hit ? w_cur_mesi : MESI_I;
            default:   w_err = 1'b1;
        endcase
        if (w_wb) w_wb_addr = {w_cur_tag, w_idx, {OFF_W{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == ST_SWEEP) begin
            for (int w = 0; w < WAYS; w++) begin
                r_mesi_arr[r_sweep_idx][w] <= MESI_I;
                r_age_arr[r_sweep_idx][w]  <= WAY_W'(w);
            end
        end else if (!rst && r_state == ST_UPDATE) begin
            if (w_do_touch) begin
                for (int w = 0; w < WAYS; w++) r_age_arr[w_idx][w] <= w_ages_new[w];
            end
            if (w_do_alloc) r_tag_arr[w_idx][r_way] <= w_tag;
            if (w_do_mesi)  r_mesi_arr[w_idx][r_way] <= w_new_mesi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_SWEEP;
            r_sweep_idx    <= '0;
            r_clr_resp     <= 1'b0;
            r_cmd          <= '0;
            r_line         <= '0;
            r_hit          <= 1'b0;
            r_way          <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_hit     <= 1'b0;
            r_resp_way     <= '0;
            r_resp_mesi    <= MESI_I;
            r_resp_wb      <= 1'b0;
            r_resp_wb_addr <= '0;
            r_resp_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_SWEEP: begin
                    r_sweep_idx <= r_sweep_idx + IDX_W'(1);
                    if (w_sweep_last && r_clr_resp) begin
                        r_clr_resp     <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_resp_hit     <= 1'b0;
                        r_resp_way     <= '0;
                        r_resp_mesi    <= MESI_I;
                        r_resp_wb      <= 1'b0;
                        r_resp_wb_addr <= '0;
                        r_resp_err     <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_cmd  <= req_cmd;
                        r_line <= req_addr[ADDR_W-1:OFF_W];
                    end
                end
                ST_LOOKUP: begin
                    r_hit <= w_hit;
                    r_way <= w_hit ? w_hit_way : (w_inv_found ? w_inv_way : w_lru_way);
                end
                ST_UPDATE: begin
                    if (r_cmd == CMD_CLR) begin
                        r_clr_resp  <= 1'b1;
                        r_sweep_idx <= '0;
                    end else begin
                        r_resp_valid   <= 1'b1;
                        r_resp_hit     <= r_hit && !w_err;
                        r_resp_way     <= w_err ? '0 : r_way;
                        r_resp_mesi    <= w_resp_mesi;
                        r_resp_wb      <= w_wb;
                        r_resp_wb_addr <= w_wb_addr;
                        r_resp_err     <= w_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_hit     = r_resp_hit;
    assign resp_way     = r_resp_way;
    assign resp_mesi    = r_resp_mesi;
    assign resp_wb      = r_resp_wb;
    assign resp_wb_addr = r_resp_wb_addr;
    assign resp_err     = r_resp_err;

`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] r_stat_rd;
    logic [CNT_W-1:0] r_stat_wr;
    logic [CNT_W-1:0] r_stat_hit;
    logic [CNT_W-1:0] r_stat_miss;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_UPDATE && r_cmd == CMD_CLR)) begin
            r_stat_rd   <= '0;
            r_stat_wr   <= '0;
            r_stat_hit  <= '0;
            r_stat_miss <= '0;
        end else if (r_state == ST_UPDATE && (w_is_rd || w_is_wr)) begin
            if (w_is_rd && r_stat_rd != '1) r_stat_rd <= r_stat_rd + CNT_W'(1);
            if (w_is_wr && r_stat_wr != '1) r_stat_wr <= r_stat_wr + CNT_W'(1);
            if (r_hit && r_stat_hit != '1) r_stat_hit <= r_stat_hit + CNT_W'(1);
            if (!r_hit && r_stat_miss != '1) r_stat_miss <= r_stat_miss + CNT_W'(1);
        end
    end

    assign stat_rd   = r_stat_rd;
    assign stat_wr   = r_stat_wr;
    assign stat_hit  = r_stat_hit;
    assign stat_miss = r_stat_miss;
`endif

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb/tb_sa_cache_ctrl.sv - directed table-driven bench for sa_cache_ctrl (WAYS=4, SETS=16, LINE_B=64)
module tb_sa_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic [1:0]  resp_mesi;
    logic        resp_wb;
    logic [31:0] resp_wb_addr;
    logic        resp_err;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_rd, stat_wr, stat_hit, stat_miss;
`endif

    sa_cache_ctrl #(
        .ADDR_W (32),
        .SETS   (16),
        .WAYS   (4),
        .LINE_B (64),
        .CNT_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way),
        .resp_mesi    (resp_mesi),
        .resp_wb      (resp_wb),
        .resp_wb_addr (resp_wb_addr),
        .resp_err     (resp_err)
`ifdef CACHE_STATS_EN
        ,
        .stat_rd      (stat_rd),
        .stat_wr      (stat_wr),
        .stat_hit     (stat_hit),
        .stat_miss    (stat_miss)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [3:0] RD = 4'd0, WR = 4'd1, IF = 4'd2, INV = 4'd3, DRQ = 4'd4, CLR = 4'd8, PRT = 4'd9, BAD = 4'hF;
    localparam logic [1:0] MI = 2'd0, MS = 2'd1, ME = 2'd2, MM = 2'd3;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        int          lat;
        logic        hit;
        logic [1:0]  way;
        logic [1:0]  mesi;
        logic        wb;
        logic [31:0] wb_addr;
        logic        err;
        int          rd, wr, sh, sm;
    } vec_t;

    vec_t vecs [25];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] addr, input int lat,
                                input logic hit, input logic [1:0] way, input logic [1:0] mesi,
                                input logic wb, input logic [31:0] wb_addr, input logic err,
                                input int rd, input int wr, input int sh, input int sm);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.lat = lat; v.hit = hit; v.way = way; v.mesi = mesi;
        v.wb = wb; v.wb_addr = wb_addr; v.err = err; v.rd = rd; v.wr = wr; v.sh = sh; v.sm = sm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [3:0] cmd, input logic [31:0] addr, output int lat);
        int w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic count_sweep(output int n, output logic saw_resp);
        n = 1;
        saw_resp = resp_valid;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
            if (req_ready) break;
            n++;
        end
    endtask

    initial begin
        int   lat;
        int   n;
        logic saw;

        vecs[0]  = mk(RD,  32'h0040, 2,  0, 0, ME, 0, 0, 0, 1, 0, 0, 1);
        vecs[1]  = mk(RD,  32'h0040, 2,  1, 0, ME, 0, 0, 0, 2, 0, 1, 1);
        vecs[2]  = mk(WR,  32'h0040, 2,  1, 0, MM, 0, 0, 0, 2, 1, 2, 1);
        vecs[3]  = mk(CLR, 32'h0000, 18, 0, 0, MI, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(RD,  32'h0040, 2,  0, 0, ME, 0, 0, 0, 1, 0, 0, 1);
        vecs[5]  = mk(RD,  32'h0440, 2,  0, 1, ME, 0, 0, 0, 2, 0, 0, 2);
        vecs[6]  = mk(RD,  32'h0840, 2,  0, 2, ME, 0, 0, 0, 3, 0, 0, 3);
        vecs[7]  = mk(RD,  32'h0C40, 2,  0, 3, ME, 0, 0, 0, 4, 0, 0, 4);
        vecs[8]  = mk(RD,  32'h1040, 2,  0, 0, ME, 0, 0, 0, 5, 0, 0, 5);
        vecs[9]  = mk(RD,  32'h0040, 2,  0, 1, ME, 0, 0, 0, 6, 0, 0, 6);
        vecs[10] = mk(CLR, 32'h0000, 18, 0, 0, MI, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(WR,  32'h1493, 2,  0, 0, MM, 0, 0, 0, 0, 1, 0, 1);
        vecs[12] = mk(RD,  32'h0080, 2,  0, 1, ME, 0, 0, 0, 1, 1, 0, 2);
        vecs[13] = mk(RD,  32'h0480, 2,  0, 2, ME, 0, 0, 0, 2, 1, 0, 3);
        vecs[14] = mk(RD,  32'h0880, 2,  0, 3, ME, 0, 0, 0, 3, 1, 0, 4);
        vecs[15] = mk(RD,  32'h0C80, 2,  0, 0, ME, 1, 32'h1480, 0, 4, 1, 0, 5);
        vecs[16] = mk(WR,  32'h04C0, 2,  0, 0, MM, 0, 0, 0, 4, 2, 0, 6);
        vecs[17] = mk(DRQ, 32'h04C0, 2,  1, 0, MS, 1, 32'h04C0, 0, 4, 2, 0, 6);
        vecs[18] = mk(INV, 32'h04C4, 2,  1, 0, MI, 0, 0, 0, 4, 2, 0, 6);
        vecs[19] = mk(RD,  32'h04C0, 2,  0, 0, ME, 0, 0, 0, 5, 2, 0, 7);
        vecs[20] = mk(BAD, 32'h04C0, 2,  0, 0, MI, 0, 0, 1, 5, 2, 0, 7);
        vecs[21] = mk(IF,  32'h04C0, 2,  1, 0, ME, 0, 0, 0, 6, 2, 1, 7);
        vecs[22] = mk(PRT, 32'h04C0, 2,  1, 0, ME, 0, 0, 0, 6, 2, 1, 7);
        vecs[23] = mk(INV, 32'h0FC0, 2,  0, 0, MI, 0, 0, 0, 6, 2, 1, 7);
        vecs[24] = mk(DRQ, 32'h04C0, 2,  1, 0, MS, 0, 0, 0, 6, 2, 1, 7);

        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_hit", {31'd0, resp_hit}, 32'd0);
        chk("rst_wb", {31'd0, resp_wb}, 32'd0);
        chk("rst_wb_addr", resp_wb_addr, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mesi", {30'd0, resp_mesi}, 32'd0);
        rst = 1'b0;
        count_sweep(n, saw);
        chk("sweep_len", n, 32'd16);
        chk("sweep_no_resp", {31'd0, saw}, 32'd0);

        for (int i = 0; i < 25; i++) begin
            do_req(vecs[i].cmd, vecs[i].addr, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_hit", i), {31'd0, resp_hit}, {31'd0, vecs[i].hit});
            chk($sformatf("v%0d_way", i), {30'd0, resp_way}, {30'd0, vecs[i].way});
            chk($sformatf("v%0d_mesi", i), {30'd0, resp_mesi}, {30'd0, vecs[i].mesi});
            chk($sformatf("v%0d_wb", i), {31'd0, resp_wb}, {31'd0, vecs[i].wb});
            chk($sformatf("v%0d_wb_addr", i), resp_wb_addr, vecs[i].wb_addr);
            chk($sformatf("v%0d_err", i), {31'd0, resp_err}, {31'd0, vecs[i].err});
`ifdef CACHE_STATS_EN
            chk($sformatf("v%0d_stat_rd", i), stat_rd, vecs[i].rd);
            chk($sformatf("v%0d_stat_wr", i), stat_wr, vecs[i].wr);
            chk($sformatf("v%0d_stat_hit", i), stat_hit, vecs[i].sh);
            chk($sformatf("v%0d_stat_miss", i), stat_miss, vecs[i].sm);
`endif
            if (i == 0) begin
                @(posedge clk); #1;
                chk("pulse_valid", {31'd0, resp_valid}, 32'd0);
                chk("hold_mesi", {30'd0, resp_mesi}, {30'd0, ME});
            end
        end

        while (!req_ready) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b1; req_cmd = RD; req_addr = 32'h04C0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        count_sweep(n, saw);
        chk("abort_sweep_len", n, 32'd16);
        chk("abort_no_resp", {31'd0, saw}, 32'd0);
        do_req(RD, 32'h04C0, lat);
        chk("post_abort_lat", lat, 32'd2);
        chk("post_abort_hit", {31'd0, resp_hit}, 32'd0);
        chk("post_abort_mesi", {30'd0, resp_mesi}, {30'd0, ME});
`ifdef CACHE_STATS_EN
        chk("post_abort_stat_miss", stat_miss, 32'd1);
        chk("post_abort_stat_rd", stat_rd, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
